// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry controller: FSM state encodings
// and the factory-default keypad code.
package parking_pkg;

    localparam int                      DEFAULT_PW_W      = 4;
    localparam logic [DEFAULT_PW_W-1:0] DEFAULT_PASS_CODE = 4'h6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'b000,
        ST_WAIT_PASS  = 3'b001,
        ST_WRONG_PASS = 3'b010,
        ST_RIGHT_PASS = 3'b011,
        ST_STOP       = 3'b100,
        ST_LOCKOUT    = 3'b101
    } gate_state_e;

endpackage

// File: rtl/parking_occupancy_counter.sv
// Saturating car counter shared by the entry and exit lanes. Simultaneous
// increment and decrement cancel out; the full flag is registered alongside
// the count so both change on the same edge.
module parking_occupancy_counter #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    logic [CNT_W-1:0] count_d, count_q;
    logic             full_d, full_q;

    // Next count: saturate at CAPACITY going up and at zero going down.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != CNT_W'(CAPACITY)) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        full_d = (count_d == CNT_W'(CAPACITY));
    end

    // Count and full flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking entry controller: password-gated barrier with retry
// limit, lockout, idle timeout and tailgate detection. One timer is shared
// between the password timeout and the lockout hold, since the FSM can never
// need both at once.
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int              CAPACITY    = 8,
    parameter int              PW_W        = DEFAULT_PW_W,
    parameter logic [PW_W-1:0] PASS_CODE   = PW_W'(DEFAULT_PASS_CODE),
    parameter int              MAX_TRIES   = 3,
    parameter int              TIMEOUT_CYC = 16,
    parameter int              LOCK_CYC    = 32,
    localparam int             CNT_W       = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sensor_entrance,
    input  logic             sensor_exit,
    input  logic             car_depart,
    input  logic             pw_valid,
    input  logic [PW_W-1:0]  password,
    output logic [2:0]       state_out,
    output logic             gate_open,
    output logic             green_led,
    output logic             red_led,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             alarm
);

    localparam int TMR_MAX = (TIMEOUT_CYC > LOCK_CYC) ? TIMEOUT_CYC : LOCK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    gate_state_e      state_d, state_q;
    logic [TRY_W-1:0] tries_d, tries_q;
    logic [TMR_W-1:0] timer_d, timer_q;
    logic             occ_inc;
    logic             gate_open_q, green_led_q, red_led_q, alarm_q;

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .CNT_W    (CNT_W)
    ) u_occupancy (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (occ_inc),
        .dec     (car_depart),
        .count   (occupancy),
        .full    (full)
    );

    // Next-state, try counter, shared timer and car-admitted pulse.
    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        timer_d = '0;
        occ_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tries_d = '0;
                if (sensor_entrance && !full) begin
                    state_d = ST_WAIT_PASS;
                end
            end
            ST_WAIT_PASS, ST_WRONG_PASS: begin
                if (pw_valid) begin
                    if (password == PASS_CODE) begin
                        state_d = ST_RIGHT_PASS;
                        tries_d = '0;
                    end else begin
                        tries_d = tries_q + TRY_W'(1);
                        if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
                            state_d = ST_LOCKOUT;
                        end else begin
                            state_d = ST_WRONG_PASS;
                        end
                    end
                end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_RIGHT_PASS: begin
                if (sensor_exit) begin
                    occ_inc = 1'b1;
                    state_d = sensor_entrance ? ST_STOP : ST_IDLE;
                end
            end
            ST_STOP: begin
                if (pw_valid && (password == PASS_CODE)) begin
                    state_d = ST_RIGHT_PASS;
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == TMR_W'(LOCK_CYC - 1)) begin
                    state_d = ST_IDLE;
                    tries_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tries_d = '0;
            end
        endcase
    end

    // FSM registers with outputs decoded from the next state so they line up with state_out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            tries_q     <= '0;
            timer_q     <= '0;
            gate_open_q <= 1'b0;
            green_led_q <= 1'b0;
            red_led_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tries_q     <= tries_d;
            timer_q     <= timer_d;
            gate_open_q <= (state_d == ST_RIGHT_PASS);
            green_led_q <= (state_d == ST_RIGHT_PASS);
            red_led_q   <= (state_d == ST_WAIT_PASS) || (state_d == ST_WRONG_PASS) ||
                           (state_d == ST_STOP)      || (state_d == ST_LOCKOUT);
            alarm_q     <= (state_d == ST_STOP) || (state_d == ST_LOCKOUT);
        end
    end

    assign state_out = state_q;
    assign gate_open = gate_open_q;
    assign green_led = green_led_q;
    assign red_led   = red_led_q;
    assign alarm     = alarm_q;

endmodule
